// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM states,
// alu_ctrl field positions and the majority helper used for carries.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    localparam int CTRL_A_INV = 3;
    localparam int CTRL_B_INV = 2;
    localparam int CTRL_OP_HI = 1;
    localparam int CTRL_OP_LO = 0;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational one-bit ALU slice: optional operand inversion, AND/OR/ADD/SLT
// result bit, carry out and raw sum bit.
module serial_bit_slice
    import alu_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic a_inv,
    input  logic b_inv,
    input  op_t  op,
    input  logic cin,
    input  logic less,
    output logic res,
    output logic cout,
    output logic sum
);

    logic a;
    logic b;

    always_comb begin
        a    = a_bit ^ a_inv;
        b    = b_bit ^ b_inv;
        sum  = a ^ b ^ cin;
        res  = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
                res  = sum;
                cout = maj(a, b, cin);
            end
            OP_SLT: begin
                res  = less;
                cout = maj(a, b, cin);
            end
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU, one bit per clock LSB first, result after WIDTH+1 cycles.
// Optional build macro SERIAL_ALU_OVF_EN enables signed overflow and SLT correction.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on an accepted start
//   RUN   | processing one bit per cycle, counter 0..WIDTH-1
//   FIN   | final result and flags registered, done pulsed next cycle
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [3:0]       ctrl;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             msb_sum;
    logic             last_bit;
    op_t              op;
    logic             bit_res;
    logic             bit_cout;
    logic             bit_sum;
    logic             ovf_msb;
    logic             set;
    logic [WIDTH-1:0] fin_result;

`ifdef SERIAL_ALU_OVF_EN
    logic             msb_cin;
`endif

    assign op       = op_t'(ctrl[CTRL_OP_HI:CTRL_OP_LO]);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state != IDLE);

    serial_bit_slice u_slice (
        .a_bit (a_sh[0]),
        .b_bit (b_sh[0]),
        .a_inv (ctrl[CTRL_A_INV]),
        .b_inv (ctrl[CTRL_B_INV]),
        .op    (op),
        .cin   (carry),
        .less  (1'b0),
        .res   (bit_res),
        .cout  (bit_cout),
        .sum   (bit_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // By FIN the carry register holds the MSB carry-out; MSB carry-in was saved.
`ifdef SERIAL_ALU_OVF_EN
    assign ovf_msb = msb_cin ^ carry;
`else
    assign ovf_msb = 1'b0;
`endif

    assign set        = msb_sum ^ ovf_msb;
    assign fin_result = (op == OP_SLT) ? {{(WIDTH-1){1'b0}}, set} : r_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            ctrl     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            msb_sum  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            msb_cin  <= 1'b0;
`endif
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= src1;
                        b_sh  <= src2;
                        ctrl  <= alu_ctrl;
                        cnt   <= '0;
                        carry <= alu_ctrl[CTRL_B_INV];
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {bit_res, r_sh[WIDTH-1:1]};
                    carry <= bit_cout;
                    if (last_bit) begin
                        msb_sum <= bit_sum;
`ifdef SERIAL_ALU_OVF_EN
                        msb_cin <= carry;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    result   <= fin_result;
                    zero     <= ~|fin_result;
                    cout     <= carry;
                    overflow <= (op == OP_ADD) & ovf_msb;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
